time_register: RTL and testbench
================================

# time_register

Time-of-day register for the desk clock. It consumes the 1 Hz, slow-set, fast-set and debounce strobes produced by the clock generator and keeps a 24-hour BCD hours:minutes:seconds count. It debounces the two raw set buttons and runs a set state machine that increments hours or minutes: once on press, then at the slow rate, then at the fast rate after a hold delay. Outputs feed the display driver directly.

## Interface
- DEBOUNCE_CNT, 32: consecutive debounce strobes with a changed input needed to accept a new button level (~7.8 ms at 4096 Hz).
- FAST_DELAY, 4: slow-set increments issued before switching to the fast rate (2 s at 2 Hz).
- i_clk  in  1  system clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_1hz_stb  in  1  one-cycle strobe, 1 Hz.
- i_slow_set_stb  in  1  one-cycle strobe, 2 Hz.
- i_fast_set_stb  in  1  one-cycle strobe, 8 Hz.
- i_debounce_stb  in  1  one-cycle strobe, 4096 Hz.
- i_set_hours  in  1  raw asynchronous button, active high.
- i_set_minutes  in  1  raw asynchronous button, active high.
- o_hours_tens  out  2  BCD 0–2.
- o_hours_ones  out  4  BCD 0–9 (0–3 when tens = 2).
- o_minutes_tens  out  3  BCD 0–5.
- o_minutes_ones  out  4  BCD 0–9.
- o_seconds_tens  out  3  BCD 0–5.
- o_seconds_ones  out  4  BCD 0–9.
- o_set_active  out  1  high while the FSM is not IDLE.

## Operation
- Debounce, per button:
  - 2-flop synchroniser, then a stable-level register and a counter sized for DEBOUNCE_CNT.
  - The counter clears whenever the synchronised level equals the stable level.
  - Otherwise the counter increments on each i_debounce_stb. On the strobe where it reaches DEBOUNCE_CNT-1, the stable level flips and the counter clears.
- Select: hours has priority. If both debounced buttons are high, only hours is set.
- FSM states and transitions:
  - IDLE: on the debounced rising edge of either button, go to SET_SLOW and issue one immediate increment to the selected field; clear the hold counter.
  - SET_SLOW: each i_slow_set_stb increments the selected field and the hold counter. When the hold counter reaches FAST_DELAY, go to SET_FAST.
  - SET_FAST: each i_fast_set_stb increments the selected field.
  - Exit: from SET_SLOW or SET_FAST, both debounced buttons low returns to IDLE on the next cycle.
  - Switching buttons mid-hold (e.g. hours released while minutes held) keeps the current state and retargets the increments to the new selection.
- Set increments:
  - Hours: wraps 23→00. No effect on minutes or seconds.
  - Minutes: wraps 59→00 with no carry into hours. Every minute increment also clears seconds to 00.
- Timekeeping:
  - In IDLE, each i_1hz_stb increments seconds, with carry 59→00 into minutes, 59→00 into hours, 23→00.
  - BCD ones digits carry into tens at 9.
  - i_1hz_stb is ignored in SET_SLOW and SET_FAST.
- Collision: if a set increment and i_1hz_stb land in the same cycle (IDLE entry cycle), the set increment is applied and the 1 Hz tick is dropped.
- Reset: all digits 0 (00:00:00), FSM IDLE, debounce stable levels 0, counters 0, o_set_active 0. Reset mid-hold aborts setting immediately; the held button must be released and re-pressed to set again.

## Timing
- All outputs are registered. A strobe in cycle N updates the outputs in cycle N+1.
- Button to first increment: 2 sync cycles, plus DEBOUNCE_CNT debounce strobes, plus 1 cycle for the edge, plus 1 register cycle.
- o_set_active rises in the same cycle the immediate increment becomes visible. It falls one cycle after both debounced levels are low.
- Full carry 23:59:59→00:00:00 completes in a single cycle with no intermediate values visible.

## Structure
- Package clock_pkg:
  - FSM state enum {IDLE, SET_SLOW, SET_FAST}.
  - Digit width constants.
  - BCD limit constants (HOURS_MAX = 23, MIN_SEC_MAX = 59).
  - BCD increment helper function: value and wrap limit in, next value and carry out.
- Sub-module button_debounce (synchroniser, counter, stable level), instantiated twice.
- Top level holds the FSM, hold counter and BCD registers.

## Test plan
- Preload 23:59:59 via the set buttons, release; one i_1hz_stb → 00:00:00 the next cycle.
- At 12:34:56, press minutes → 12:35:00 immediately, o_set_active = 1. Then 4 slow strobes → 12:39:00 and state SET_FAST; 3 fast strobes → 12:42:00; release → IDLE and 1 Hz counting resumes.
- Hours at 23, hold hours through 1 slow strobe → 00 then 01; minutes and seconds unchanged.
- Raw button glitch high for DEBOUNCE_CNT-1 debounce strobes then low → no increment, o_set_active stays 0.
- Both buttons pressed at 10:20:30 → hours 11, minutes 20, seconds unchanged.
- Assert reset while in SET_FAST with the button held → 00:00:00, IDLE. With the button still held after reset, no increments until release and re-press.

Source files
------------

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module : clock_pkg
// Brief  : Shared types, digit widths and BCD increment helper for the
//          desk-clock time-of-day register.
// Rev    : 1.0  initial release
// ============================================================================
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_SLOW = 2'd1,
    SET_FAST = 2'd2
  } state_t;

  localparam int HOURS_TENS_W = 2;
  localparam int MIN_TENS_W   = 3;
  localparam int SEC_TENS_W   = 3;
  localparam int ONES_W       = 4;

  localparam logic [7:0] HOURS_MAX   = 8'h23;
  localparam logic [7:0] MIN_SEC_MAX = 8'h59;

  typedef struct packed {
    logic       carry;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_inc_t;

  // Two-digit BCD increment; wraps to 00 and raises carry at the limit.
  function automatic bcd_inc_t bcd_inc(input logic [3:0] tens,
                                       input logic [3:0] ones,
                                       input logic [7:0] max_bcd);
    bcd_inc_t r;
    r = '0;
    if ({tens, ones} == max_bcd) begin
      r.carry = 1'b1;
    end else if (ones == 4'd9) begin
      r.tens = tens + 4'd1;
    end else begin
      r.tens = tens;
      r.ones = ones + 4'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module : button_debounce
// Brief  : Two-flop synchroniser plus strobe-counted debounce of one button.
// Rev    : 1.0  initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_CNT = 32
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_stb,
  input  logic i_raw,
  output logic o_sync,
  output logic o_level
);

  localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CNT - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // Synchroniser resets high so a button held through reset is not seen as released.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sync  <= 2'b11;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (i_stb) begin
        if (r_cnt == c_cnt_last) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_sync  = r_sync[1];
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/time_register.sv
`default_nettype none
// ============================================================================
// Module : time_register
// Brief  : 24-hour BCD time-of-day register with debounced hour/minute set.
// Rev    : 1.0  initial release
// ============================================================================
module time_register
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 32,
  parameter int FAST_DELAY   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_1hz_stb,
  input  logic                    i_slow_set_stb,
  input  logic                    i_fast_set_stb,
  input  logic                    i_debounce_stb,
  input  logic                    i_set_hours,
  input  logic                    i_set_minutes,
  output logic [HOURS_TENS_W-1:0] o_hours_tens,
  output logic [ONES_W-1:0]       o_hours_ones,
  output logic [MIN_TENS_W-1:0]   o_minutes_tens,
  output logic [ONES_W-1:0]       o_minutes_ones,
  output logic [SEC_TENS_W-1:0]   o_seconds_tens,
  output logic [ONES_W-1:0]       o_seconds_ones,
  output logic                    o_set_active
);

  localparam int HOLD_W = (FAST_DELAY > 0) ? $clog2(FAST_DELAY + 1) : 1;
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(FAST_DELAY - 1);

  logic w_h_sync, w_m_sync, w_h_db, w_m_db;
  logic r_h_prev, r_m_prev, r_h_armed, r_m_armed;
  logic w_rise_any, w_any_held;

  state_t r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic r_set_active;
  logic w_set_step, w_hold_step, w_tick, w_inc_hours, w_inc_min;

  logic [HOURS_TENS_W-1:0] r_ht;
  logic [MIN_TENS_W-1:0]   r_mt;
  logic [SEC_TENS_W-1:0]   r_st;
  logic [ONES_W-1:0]       r_ho, r_mo, r_so;
  bcd_inc_t w_h_inc, w_m_inc, w_s_inc;
  logic     w_unused_bits;

  button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_hours (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stb(i_debounce_stb),
    .i_raw(i_set_hours), .o_sync(w_h_sync), .o_level(w_h_db)
  );

  button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_minutes (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stb(i_debounce_stb),
    .i_raw(i_set_minutes), .o_sync(w_m_sync), .o_level(w_m_db)
  );

  // A button only arms once it has been seen released since reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_h_prev  <= 1'b0;
      r_m_prev  <= 1'b0;
      r_h_armed <= 1'b0;
      r_m_armed <= 1'b0;
    end else begin
      r_h_prev <= w_h_db;
      r_m_prev <= w_m_db;
      if (!w_h_sync) r_h_armed <= 1'b1;
      if (!w_m_sync) r_m_armed <= 1'b1;
    end
  end

  assign w_rise_any = (w_h_db & ~r_h_prev & r_h_armed) | (w_m_db & ~r_m_prev & r_m_armed);
  assign w_any_held = w_h_db | w_m_db;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_set_active <= 1'b0;
      r_hold       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_set_active <= (w_state_nxt != IDLE);
      if (r_state == IDLE)  r_hold <= '0;
      else if (w_hold_step) r_hold <= r_hold + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (w_rise_any) w_state_nxt = SET_SLOW;
      SET_SLOW: begin
        if (!w_any_held)                                w_state_nxt = IDLE;
        else if (i_slow_set_stb && r_hold == c_hold_last) w_state_nxt = SET_FAST;
      end
      SET_FAST: if (!w_any_held) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_set_step  = 1'b0;
    w_hold_step = 1'b0;
    w_tick      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_set_step = w_rise_any;
        w_tick     = i_1hz_stb & ~w_rise_any;
      end
      SET_SLOW: begin
        w_set_step  = w_any_held & i_slow_set_stb;
        w_hold_step = w_any_held & i_slow_set_stb;
      end
      SET_FAST: w_set_step = w_any_held & i_fast_set_stb;
      default:  w_set_step = 1'b0;
    endcase
    w_inc_hours = w_set_step & w_h_db;
    w_inc_min   = w_set_step & ~w_h_db & w_m_db;
  end

  assign w_h_inc = bcd_inc({2'b00, r_ht}, r_ho, HOURS_MAX);
  assign w_m_inc = bcd_inc({1'b0, r_mt}, r_mo, MIN_SEC_MAX);
  assign w_s_inc = bcd_inc({1'b0, r_st}, r_so, MIN_SEC_MAX);
  assign w_unused_bits = ^{w_h_inc.carry, w_h_inc.tens[3:2], w_m_inc.tens[3], w_s_inc.tens[3]};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ht <= '0; r_ho <= '0;
      r_mt <= '0; r_mo <= '0;
      r_st <= '0; r_so <= '0;
    end else if (w_inc_hours) begin
      r_ht <= w_h_inc.tens[HOURS_TENS_W-1:0];
      r_ho <= w_h_inc.ones;
    end else if (w_inc_min) begin
      r_mt <= w_m_inc.tens[MIN_TENS_W-1:0];
      r_mo <= w_m_inc.ones;
      r_st <= '0;
      r_so <= '0;
    end else if (w_tick) begin
      r_st <= w_s_inc.tens[SEC_TENS_W-1:0];
      r_so <= w_s_inc.ones;
      if (w_s_inc.carry) begin
        r_mt <= w_m_inc.tens[MIN_TENS_W-1:0];
        r_mo <= w_m_inc.ones;
        if (w_m_inc.carry) begin
          r_ht <= w_h_inc.tens[HOURS_TENS_W-1:0];
          r_ho <= w_h_inc.ones;
        end
      end
    end
  end

  assign o_hours_tens   = r_ht;
  assign o_hours_ones   = r_ho;
  assign o_minutes_tens = r_mt;
  assign o_minutes_ones = r_mo;
  assign o_seconds_tens = r_st;
  assign o_seconds_ones = r_so;
  assign o_set_active   = r_set_active;

endmodule
`default_nettype wire

// File: tb/tb_time_register.sv
`default_nettype none
// ============================================================================
// Module : tb_time_register
// Brief  : Self-checking bench for time_register against a seconds-of-day model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_time_register;

  localparam int DEB = 32;
  localparam int FD  = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic hz = 1'b0, slow = 1'b0, fast = 1'b0, deb = 1'b0, bh = 1'b0, bm = 1'b0;
  logic [1:0] ht;
  logic [3:0] ho, mo, so;
  logic [2:0] mt, st;
  logic       act;

  time_register #(.DEBOUNCE_CNT(DEB), .FAST_DELAY(FD)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_1hz_stb(hz), .i_slow_set_stb(slow), .i_fast_set_stb(fast), .i_debounce_stb(deb),
    .i_set_hours(bh), .i_set_minutes(bm),
    .o_hours_tens(ht), .o_hours_ones(ho), .o_minutes_tens(mt), .o_minutes_ones(mo),
    .o_seconds_tens(st), .o_seconds_ones(so), .o_set_active(act)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_mis = 0;
  int t_sec = 0;
  int m_slow = 0;
  bit m_sel_h = 1'b0;

  typedef struct {
    bit hz1, sl1, fa1;
    int exp_sec;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [19:0] to_bcd(input int t);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [19:0] dut_time();
    return {ht, ho, mt, mo, st, so};
  endfunction

  function automatic int field(input int t, input bit h);
    return h ? t / 3600 : (t / 60) % 60;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit h1, input bit s1, input bit f1, input bit d1);
    hz = h1; slow = s1; fast = f1; deb = d1;
    @(posedge clk); #1;
    hz = 1'b0; slow = 1'b0; fast = 1'b0; deb = 1'b0;
  endtask

  // Reference model: whole-field arithmetic on seconds-of-day.
  task automatic apply_sel();
    int h, m;
    h = t_sec / 3600; m = (t_sec / 60) % 60;
    if (m_sel_h) t_sec = ((h + 1) % 24) * 3600 + (t_sec % 3600);
    else         t_sec = h * 3600 + ((m + 1) % 60) * 60;
  endtask

  // kind: 0 slow, 1 fast, 2 one-hertz (ignored while setting)
  task automatic hold_pulse(input int kind);
    cyc(kind == 2, kind == 0, kind == 1, 1'b0);
    if (kind == 0 && m_slow < FD) begin apply_sel(); m_slow++; end
    else if (kind == 1 && m_slow >= FD) apply_sel();
  endtask

  task automatic press(input bit h, input bit m);
    bh = h; bm = m;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    repeat (DEB) cyc(0, 0, 0, 1);
    chk("press_early", act, 0);
    for (int k = 0; k < 3 && !act; k++) cyc(0, 0, 0, 0);
    chk("press_active", act, 1);
    m_sel_h = h; m_slow = 0;
    apply_sel();
    chk("press_value", dut_time(), to_bcd(t_sec));
  endtask

  task automatic release_btn();
    bh = 1'b0; bm = 1'b0;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    repeat (DEB) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("release_idle", act, 0);
  endtask

  task automatic set_field(input bit h, input int target);
    press(h, !h);
    for (int i = 0; i < 70; i++) begin
      if (field(t_sec, h) == target) break;
      hold_pulse(m_slow < FD ? 0 : 1);
    end
    chk("set_field", dut_time(), to_bcd(t_sec));
    release_btn();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin cyc(1, 0, 0, 0); t_sec = (t_sec + 1) % 86400; end
  endtask

  initial begin
    bit h1, s1, f1, d1, seen;
    int sel, n;

    tbl[0] = '{1, 0, 0, 1}; tbl[1] = '{0, 1, 0, 1}; tbl[2] = '{0, 0, 1, 1};
    tbl[3] = '{1, 1, 1, 2}; tbl[4] = '{0, 0, 0, 2}; tbl[5] = '{1, 0, 0, 3};
    tbl[6] = '{1, 0, 1, 4}; tbl[7] = '{0, 1, 1, 4};

    repeat (3) cyc(0, 0, 0, 0);
    chk("reset_time", dut_time(), 20'h0);
    chk("reset_active", act, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("post_reset_time", dut_time(), 20'h0);

    foreach (tbl[i]) begin
      cyc(tbl[i].hz1, tbl[i].sl1, tbl[i].fa1, 1'b0);
      chk("table_time", dut_time(), to_bcd(tbl[i].exp_sec));
      chk("table_active", act, 0);
    end
    t_sec = 4;

    // Midnight rollover in one cycle
    set_field(1, 23);
    set_field(0, 59);
    ticks(59);
    chk("preload_235959", dut_time(), {2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9});
    ticks(1);
    chk("rollover", dut_time(), 20'h0);

    // Minute set, slow then fast rate
    set_field(1, 12);
    set_field(0, 34);
    ticks(56);
    press(0, 1);
    chk("min_press", dut_time(), {2'd1, 4'd2, 3'd3, 4'd5, 3'd0, 4'd0});
    repeat (FD) hold_pulse(0);
    chk("slow4", dut_time(), {2'd1, 4'd2, 3'd3, 4'd9, 3'd0, 4'd0});
    hold_pulse(2);
    hold_pulse(0);
    chk("fast_ignores_slow_hz", dut_time(), {2'd1, 4'd2, 3'd3, 4'd9, 3'd0, 4'd0});
    repeat (3) hold_pulse(1);
    chk("fast3", dut_time(), {2'd1, 4'd2, 3'd4, 4'd2, 3'd0, 4'd0});
    release_btn();
    ticks(1);
    chk("resume_1hz", dut_time(), {2'd1, 4'd2, 3'd4, 4'd2, 3'd0, 4'd1});

    // Hours wrap 23 -> 00 -> 01
    set_field(1, 23);
    press(1, 0);
    chk("hours_wrap", {28'd0, ht, ho}, 32'h00);
    hold_pulse(0);
    chk("hours_01", dut_time(), {2'd0, 4'd1, 3'd4, 4'd2, 3'd0, 4'd1});
    release_btn();

    // Glitch one strobe short of acceptance
    seen = 1'b0;
    bh = 1'b1;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    repeat (DEB - 1) begin cyc(0, 0, 0, 1); seen |= act; end
    bh = 1'b0;
    repeat (3) begin cyc(0, 0, 0, 0); seen |= act; end
    repeat (40) begin cyc(0, 0, 0, 1); seen |= act; end
    chk("glitch_no_active", seen, 0);
    chk("glitch_no_change", dut_time(), to_bcd(t_sec));

    // Both buttons: hours wins
    set_field(1, 10);
    set_field(0, 20);
    ticks(30);
    press(1, 1);
    chk("both_buttons", dut_time(), {2'd1, 4'd1, 3'd2, 4'd0, 3'd3, 4'd0});
    release_btn();

    // Random ticks across midnight
    set_field(1, 23);
    set_field(0, 59);
    ticks(30);
    for (int i = 0; i < 300; i++) begin
      h1 = ($urandom % 3) == 0; s1 = $urandom % 2; f1 = $urandom % 2; d1 = $urandom % 2;
      cyc(h1, s1, f1, d1);
      if (h1) t_sec = (t_sec + 1) % 86400;
      chk("rand_tick", dut_time(), to_bcd(t_sec));
    end

    // Random holds
    for (int i = 0; i < 6; i++) begin
      sel = $urandom_range(1, 3);
      press(sel != 2, sel >= 2);
      n = $urandom_range(0, 10);
      repeat (n) hold_pulse($urandom_range(0, 2));
      chk("rand_hold", dut_time(), to_bcd(t_sec));
      release_btn();
    end
    ticks(3);
    chk("rand_resume", dut_time(), to_bcd(t_sec));

    // Reset while fast-setting with the button held
    press(1, 0);
    repeat (FD) hold_pulse(0);
    hold_pulse(1);
    chk("pre_reset_fast", dut_time(), to_bcd(t_sec));
    rst_n = 1'b0;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    t_sec = 0;
    cyc(0, 0, 0, 0);
    chk("midhold_reset_time", dut_time(), 20'h0);
    chk("midhold_reset_active", act, 0);
    seen = 1'b0;
    repeat (60) begin cyc(0, 1, 1, 1); seen |= act; end
    chk("held_no_set", seen, 0);
    chk("held_no_change", dut_time(), 20'h0);
    release_btn();
    press(1, 0);
    chk("repress_hours", dut_time(), {2'd0, 4'd1, 3'd0, 4'd0, 3'd0, 4'd0});
    release_btn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
